button_detector_multi: RTL and testbench
========================================

# button_detector_multi

Parametrised multi-channel button conditioner, the successor to the single-channel 8-sample debounce/edge detector. It takes NUM_BTN raw asynchronous button lines and synchronises each one, then debounces it with a programmable sample tick and stable-count threshold. Per channel it produces a clean level, one-cycle edge pulses, a long-press pulse and auto-repeat pulses. It sits between board push-buttons and the CPU/peripheral control logic, e.g. menu or step controls.

## Interface
- NUM_BTN, 4: number of independent button channels, ≥1.
- TICK_DIV, 100_000: clk cycles per debounce sample tick, ≥1 (1 = sample every cycle).
- STABLE_CNT, 8: consecutive differing samples needed to flip the debounced level, ≥1.
- LONG_CNT, 1000: ticks of continuous press before long_press fires, ≥1.
- REPEAT_CNT, 200: ticks between repeat_pulse after long press, ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_button  in  NUM_BTN  raw asynchronous button inputs, active-high.
- level  out  NUM_BTN  debounced level.
- rising_edge  out  NUM_BTN  1-cycle pulse when level goes 0→1.
- falling_edge  out  NUM_BTN  1-cycle pulse when level goes 1→0.
- both_edge  out  NUM_BTN  rising_edge | falling_edge.
- long_press  out  NUM_BTN  1-cycle pulse when a press reaches LONG_CNT ticks.
- repeat_pulse  out  NUM_BTN  1-cycle pulse every REPEAT_CNT ticks after long_press while still held.

## Operation
- Synchroniser: 2-flop chain per channel, reset to 0; its output is the "sample".
- Tick generator: shared counter 0..TICK_DIV-1, width $clog2(TICK_DIV+1).
  - tick is high in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
  - TICK_DIV=1 gives tick high every cycle.
- Debounce, per channel, stable counter width $clog2(STABLE_CNT+1), evaluated only on tick cycles:
  - sample == level: counter cleared.
  - sample != level and counter == STABLE_CNT-1: level toggles and the counter clears.
  - Otherwise sample != level: counter increments.
  - Any single matching sample clears the counter, so glitches shorter than STABLE_CNT ticks never reach level.
- Edge outputs are registered. They assert in the same cycle level first shows its new value, for exactly one clk. both_edge is an OR of the two.
- Hold FSM per channel. States are IDLE, HELD and REPEAT; hold counter width $clog2(max(LONG_CNT,REPEAT_CNT)+1).
  - IDLE: hold counter 0. On a level 0→1 update go to HELD with counter 0.
  - HELD: on tick, counter increments. When an increment makes it equal LONG_CNT, pulse long_press, clear the counter and go to REPEAT.
  - REPEAT: on tick, counter increments. When it reaches REPEAT_CNT, pulse repeat_pulse and clear the counter.
  - Any state: a level 1→0 update returns the FSM to IDLE and clears the counter. No long_press or repeat_pulse fires in that cycle.
- Channels are fully independent and share only the tick. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset:
  - All outputs 0; tick counter, synchronisers, stable/hold counters 0; FSMs IDLE.
  - Takes effect on the next clk edge and overrides everything else. An assertion mid-press or mid-repeat discards all state.
  - After reset release with a button already held, the normal press latency applies, then rising_edge fires.
- Latency with TICK_DIV=1: level and the edge pulse appear STABLE_CNT+2 cycles after an in_button transition that stays stable.
  - 2 cycles are the synchroniser; STABLE_CNT are samples.
- With TICK_DIV>1, add up to TICK_DIV-1 cycles of tick phase, times the sample spacing.
- long_press: LONG_CNT ticks after the tick on which level rose.
- First repeat_pulse: REPEAT_CNT ticks after long_press; subsequent pulses are spaced by the same REPEAT_CNT ticks.
- Each pulse output is high for exactly one clk, never on consecutive cycles unless TICK_DIV=1 and REPEAT_CNT=1.

## Test plan
- Clean press, TICK_DIV=1, STABLE_CNT=4:
  - Stimulus: in_button[0] 0→1 at cycle 10.
  - Response: level[0]=1 and rising_edge[0]=1 at cycle 16 only; both_edge[0] matches.
  - Release at cycle 30: falling_edge[0] at cycle 36.
- Bounce rejection, same parameters: pulses of 1, 2 and 3 cycles, gaps ≥3 cycles → level stays 0 and no edges fire.
- Long press and repeat, TICK_DIV=2, STABLE_CNT=2, LONG_CNT=10, REPEAT_CNT=3, held 60 cycles:
  - long_press once, 20 cycles after rising_edge.
  - repeat_pulse every 6 cycles thereafter.
  - Release stops pulses; falling_edge fires; the FSM is back in IDLE.
- Release just before threshold, same parameters: held so level is high for 9 ticks → no long_press, no repeat_pulse.
- Multi-channel, NUM_BTN=4:
  - Channels 0 and 3 press in the same cycle → rising_edge=4'b1001 in a single cycle.
  - Channel 1 bouncing meanwhile → no output on channel 1.
- Reset mid-operation: rst high for 1 cycle while channel 0 is in REPEAT → next cycle all outputs are 0; with the button still held, rising_edge re-fires after STABLE_CNT+2 cycles.

Source files
------------

// File: rtl/button_detector_multi.sv
// button_detector_multi: multi-channel push-button conditioner.
// Each raw button line is synchronised, debounced on a shared sample tick and
// then fed to a per-channel hold FSM that generates long-press and
// auto-repeat pulses.
//
// Ports:
//   clk           system clock (only clock)
//   rst           synchronous, active-high reset
//   in_button     raw asynchronous button inputs, active-high
//   level         debounced button level
//   rising_edge   1-cycle pulse when level goes 0->1
//   falling_edge  1-cycle pulse when level goes 1->0
//   both_edge     rising_edge | falling_edge
//   long_press    1-cycle pulse when a press has lasted LONG_CNT ticks
//   repeat_pulse  1-cycle pulse every REPEAT_CNT ticks after long_press while held
module button_detector_multi #(
   parameter int unsigned NUM_BTN    = 4,
   parameter int unsigned TICK_DIV   = 100_000,
   parameter int unsigned STABLE_CNT = 8,
   parameter int unsigned LONG_CNT   = 1000,
   parameter int unsigned REPEAT_CNT = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] in_button,
   output logic [NUM_BTN-1:0] level,
   output logic [NUM_BTN-1:0] rising_edge,
   output logic [NUM_BTN-1:0] falling_edge,
   output logic [NUM_BTN-1:0] both_edge,
   output logic [NUM_BTN-1:0] long_press,
   output logic [NUM_BTN-1:0] repeat_pulse
);

   localparam int unsigned TW      = $clog2(TICK_DIV + 1);
   localparam int unsigned SW      = $clog2(STABLE_CNT + 1);
   localparam int unsigned HoldMax = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
   localparam int unsigned HW      = $clog2(HoldMax + 1);

   localparam logic [TW-1:0] TickLast   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] StableLast = SW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] LongVal    = HW'(LONG_CNT);
   localparam logic [HW-1:0] RepeatVal  = HW'(REPEAT_CNT);

   typedef enum logic [1:0] {StIdle, StHeld, StRepeat} hold_st_e;

   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic               tick;
   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] rise_q, rise_d;
   logic [NUM_BTN-1:0] fall_q, fall_d;
   logic [NUM_BTN-1:0] long_q, long_d;
   logic [NUM_BTN-1:0] rep_q, rep_d;
   logic [SW-1:0]      stable_q [NUM_BTN];
   logic [SW-1:0]      stable_d [NUM_BTN];
   logic [HW-1:0]      hold_q   [NUM_BTN];
   logic [HW-1:0]      hold_d   [NUM_BTN];
   hold_st_e           st_q     [NUM_BTN];
   hold_st_e           st_d     [NUM_BTN];

   always_comb begin
      tick       = (tick_cnt_q == TickLast);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

      for (int i = 0; i < int'(NUM_BTN); i++) begin
         level_d[i]  = level_q[i];
         stable_d[i] = stable_q[i];
         hold_d[i]   = hold_q[i];
         st_d[i]     = st_q[i];
         long_d[i]   = 1'b0;
         rep_d[i]    = 1'b0;

         // Any matching sample restarts the stability count.
         if (tick) begin
            if (sync2_q[i] == level_q[i]) begin
               stable_d[i] = '0;
            end else if (stable_q[i] == StableLast) begin
               level_d[i]  = ~level_q[i];
               stable_d[i] = '0;
            end else begin
               stable_d[i] = stable_q[i] + SW'(1);
            end
         end

         rise_d[i] = level_d[i] & ~level_q[i];
         fall_d[i] = ~level_d[i] & level_q[i];

         // A release wins over any pulse due on the same tick.
         if (fall_d[i]) begin
            st_d[i]   = StIdle;
            hold_d[i] = '0;
         end else begin
            unique case (st_q[i])
               StIdle: begin
                  hold_d[i] = '0;
                  if (rise_d[i]) st_d[i] = StHeld;
               end
               StHeld: begin
                  if (tick) begin
                     if ((hold_q[i] + HW'(1)) == LongVal) begin
                        long_d[i] = 1'b1;
                        hold_d[i] = '0;
                        st_d[i]   = StRepeat;
                     end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                     end
                  end
               end
               StRepeat: begin
                  if (tick) begin
                     if ((hold_q[i] + HW'(1)) == RepeatVal) begin
                        rep_d[i]  = 1'b1;
                        hold_d[i] = '0;
                     end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                     end
                  end
               end
               default: begin
                  st_d[i]   = StIdle;
                  hold_d[i] = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         level_q    <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         long_q     <= '0;
         rep_q      <= '0;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            stable_q[i] <= '0;
            hold_q[i]   <= '0;
            st_q[i]     <= StIdle;
         end
      end else begin
         tick_cnt_q <= tick_cnt_d;
         sync1_q    <= in_button;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         long_q     <= long_d;
         rep_q      <= rep_d;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            stable_q[i] <= stable_d[i];
            hold_q[i]   <= hold_d[i];
            st_q[i]     <= st_d[i];
         end
      end
   end

   assign level        = level_q;
   assign rising_edge  = rise_q;
   assign falling_edge = fall_q;
   assign both_edge    = rise_q | fall_q;
   assign long_press   = long_q;
   assign repeat_pulse = rep_q;

endmodule

// File: tb/tb_button_detector_multi.sv
// Bench for button_detector_multi. Instance A runs with TICK_DIV=1 for exact
// cycle timing; instance B runs with TICK_DIV=2 and is checked relative to
// its observed rising edge, since its tick phase is free-running.
module tb_button_detector_multi;

   logic clk;
   logic rst_a, rst_b;
   logic [3:0] in_a, in_b;
   logic [3:0] level_a, rise_a, fall_a, both_a, long_a, rep_a;
   logic [3:0] level_b, rise_b, fall_b, both_b, long_b, rep_b;

   int n_checks = 0;
   int n_fail   = 0;

   button_detector_multi #(
      .NUM_BTN(4), .TICK_DIV(1), .STABLE_CNT(4), .LONG_CNT(6), .REPEAT_CNT(3)
   ) u_dut_a (
      .clk(clk), .rst(rst_a), .in_button(in_a), .level(level_a),
      .rising_edge(rise_a), .falling_edge(fall_a), .both_edge(both_a),
      .long_press(long_a), .repeat_pulse(rep_a)
   );

   button_detector_multi #(
      .NUM_BTN(4), .TICK_DIV(2), .STABLE_CNT(2), .LONG_CNT(10), .REPEAT_CNT(3)
   ) u_dut_b (
      .clk(clk), .rst(rst_b), .in_button(in_b), .level(level_b),
      .rising_edge(rise_b), .falling_edge(fall_b), .both_edge(both_b),
      .long_press(long_b), .repeat_pulse(rep_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clean press at cycle 10, release at cycle 30 on channel 0.
   task automatic test_clean();
      for (int k = 1; k <= 45; k++) begin
         step();
         if (k == 10) in_a[0] = 1'b1;
         if (k == 30) in_a[0] = 1'b0;
         check_eq("a_clean_rise", 32'(rise_a[0]), 32'(k == 16));
         check_eq("a_clean_level", 32'(level_a[0]), 32'(k >= 16 && k < 36));
         check_eq("a_clean_fall", 32'(fall_a[0]), 32'(k == 36));
         check_eq("a_clean_both", 32'(both_a[0]), 32'(k == 16 || k == 36));
         check_eq("a_clean_long", 32'(long_a[0]), 32'(k == 22));
         check_eq("a_clean_rep", 32'(rep_a[0]), 32'(k == 25 || k == 28 || k == 31 || k == 34));
      end
   endtask

   // Glitches of 1, 2 and 3 cycles must never reach level.
   task automatic test_bounce();
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 2 || k == 6 || k == 11) in_a[0] = 1'b1;
         if (k == 3 || k == 8 || k == 14) in_a[0] = 1'b0;
         check_eq("a_bounce_level", 32'(level_a), 32'h0);
         check_eq("a_bounce_edges", 32'(both_a), 32'h0);
      end
   endtask

   // Channels 0 and 3 pressed together while channel 1 bounces.
   task automatic test_multi();
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 5)  begin in_a[0] = 1'b1; in_a[3] = 1'b1; end
         if (k == 18) begin in_a[0] = 1'b0; in_a[3] = 1'b0; end
         if (k <= 22 && (k % 4) == 0) in_a[1] = 1'b1;
         if (k <= 22 && (k % 4) == 2) in_a[1] = 1'b0;
         check_eq("a_multi_rise", 32'(rise_a), (k == 11) ? 32'h9 : 32'h0);
         check_eq("a_multi_fall", 32'(fall_a), (k == 24) ? 32'h9 : 32'h0);
         check_eq("a_multi_level", 32'(level_a), (k >= 11 && k < 24) ? 32'h9 : 32'h0);
         check_eq("a_multi_long", 32'(long_a), (k == 17) ? 32'h9 : 32'h0);
         check_eq("a_multi_rep", 32'(rep_a), (k == 20 || k == 23) ? 32'h9 : 32'h0);
      end
   endtask

   // One-cycle reset while channel 0 is auto-repeating, button kept held.
   task automatic test_reset();
      for (int k = 1; k <= 36; k++) begin
         step();
         if (k == 2)  in_a[0] = 1'b1;
         if (k == 18) rst_a = 1'b1;
         if (k == 19) rst_a = 1'b0;
         check_eq("a_rst_rise", 32'(rise_a[0]), 32'(k == 8 || k == 25));
         check_eq("a_rst_level", 32'(level_a[0]), 32'((k >= 8 && k <= 18) || k >= 25));
         check_eq("a_rst_long", 32'(long_a[0]), 32'(k == 14 || k == 31));
         check_eq("a_rst_rep", 32'(rep_a[0]), 32'(k == 17 || k == 34));
         if (k == 19)
            check_eq("a_rst_all", 32'({level_a, rise_a, fall_a, both_a, long_a, rep_a}), 32'h0);
      end
      in_a[0] = 1'b0;
      for (int k = 1; k <= 10; k++) step();
      check_eq("a_rst_idle", 32'(level_a), 32'h0);
   endtask

   // Hold channel 0 of B for hold cycles; all timing relative to rising_edge.
   task automatic hold_b(input int hold);
      int kr = -1;
      int d;
      in_b[0] = 1'b1;
      for (int k = 1; k <= hold + 15; k++) begin
         step();
         if (k == hold) in_b[0] = 1'b0;
         if (kr < 0 && rise_b[0] == 1'b1) kr = k;
         if (kr < 0) begin
            check_eq("b_pre_pulses", 32'({long_b[0], rep_b[0], fall_b[0]}), 32'h0);
         end else begin
            d = k - kr;
            if (d > 0) check_eq("b_rise", 32'(rise_b[0]), 32'h0);
            check_eq("b_level", 32'(level_b[0]), 32'(d < hold));
            check_eq("b_long", 32'(long_b[0]), 32'(d == 20 && hold > 20));
            check_eq("b_rep", 32'(rep_b[0]),
                     32'(d >= 26 && d < hold && ((d - 20) % 6) == 0));
            check_eq("b_fall", 32'(fall_b[0]), 32'(d == hold));
         end
      end
      check_eq("b_rise_latency", 32'(kr == 5 || kr == 6), 32'h1);
   endtask

   initial begin
      in_a  = '0;
      in_b  = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      step();
      step();
      step();
      rst_a = 1'b0;
      rst_b = 1'b0;
      check_eq("reset_a", 32'({level_a, rise_a, fall_a, both_a, long_a, rep_a}), 32'h0);
      check_eq("reset_b", 32'({level_b, rise_b, fall_b, both_b, long_b, rep_b}), 32'h0);
      step();
      step();

      test_clean();
      test_bounce();
      test_multi();
      test_reset();

      hold_b(60);
      hold_b(18);
      hold_b(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
